// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - FIFO read-side drain that packs PACK_RATIO entries per output word
//
// Pops DATA_WIDTH-bit entries from a 1-cycle-latency FIFO read port and packs
// PACK_RATIO of them into one OUT_WIDTH word on a valid/ready stream. A flush
// request forces any partial word out with a keep mask and out_last set.
//
// Ports:
//   rd_clk, rd_rst_n   clock, asynchronous active-low reset
//   rd_en              FIFO pop request (combinational)
//   rd_data, empty     FIFO read data (valid the cycle after rd_en) and empty flag
//   flush              request to emit the partial word
//   out_valid/ready    output stream handshake
//   out_data           packed word, first-popped entry in the low slot
//   out_keep           per-slot valid mask
//   out_last           word produced by a flush
//   flush_done         one-cycle pulse when a flush completes
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 4,
   localparam int OUT_WIDTH = DATA_WIDTH * PACK_RATIO
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  empty,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic [PACK_RATIO-1:0] out_keep,
   output logic                  out_last,
   output logic                  flush_done
);

   localparam int CNT_W = $clog2(PACK_RATIO + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_RATIO);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  inflight_q, inflight_d;
   logic [DATA_WIDTH-1:0] slot_q [PACK_RATIO];
   logic [DATA_WIDTH-1:0] slot_d [PACK_RATIO];
   logic                  out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
   logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
   logic                  out_last_q, out_last_d;

   logic                  out_free;
   logic                  load;
   logic                  load_last;
   logic [PACK_RATIO-1:0] load_keep;
   logic [CNT_W:0]        pending;

   // Entries already captured plus the one still in the FIFO read pipeline;
   // popping stops once these would fill the accumulator.
   assign pending  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
   assign out_free = !out_valid_q || out_ready;
   // Gated by reset so the pop request is low while reset is held.
   assign rd_en    = rd_rst_n && !empty && (state_q == ST_RUN) && (pending < {1'b0, CNT_FULL});

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      inflight_d  = rd_en;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      flush_done  = 1'b0;
      load        = 1'b0;
      load_last   = 1'b0;
      load_keep   = '1;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (inflight_q) begin
         for (int i = 0; i < PACK_RATIO; i++) begin
            if (cnt_q == CNT_W'(i)) begin
               slot_d[i] = rd_data;
            end
         end
         // Completing entry goes straight to the output when it can;
         // otherwise the full word is parked with cnt == PACK_RATIO.
         if ((cnt_q == CNT_FULL - CNT_W'(1)) && out_free) begin
            load  = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if ((state_q == ST_RUN) && (cnt_q == CNT_FULL) && out_free) begin
         load  = 1'b1;
         cnt_d = '0;
      end

      if (state_q == ST_RUN) begin
         if (flush) begin
            state_d = ST_FLUSH;
         end
      end else if (!inflight_q) begin
         if (cnt_q == '0) begin
            flush_done = 1'b1;
            state_d    = ST_RUN;
         end else if (out_free) begin
            load       = 1'b1;
            load_last  = 1'b1;
            cnt_d      = '0;
            flush_done = 1'b1;
            state_d    = ST_RUN;
            for (int i = 0; i < PACK_RATIO; i++) begin
               load_keep[i] = (CNT_W'(i) < cnt_q);
            end
         end
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_keep_d  = load_keep;
         out_last_d  = load_last;
         // Slots outside the keep mask may hold bytes of an older word.
         for (int i = 0; i < PACK_RATIO; i++) begin
            out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = load_keep[i] ? slot_d[i] : '0;
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         inflight_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < PACK_RATIO; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         inflight_q  <= inflight_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         slot_q      <= slot_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_last  = out_last_q;

endmodule
